// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared definitions for the traffic phase controller: phase codes, lamp
// encodings, display width, and helpers for phase duration and lamp decode.
package traffic_phase_ctrl_pkg;

  localparam int unsigned REMAIN_W   = 7;
  localparam int unsigned SEC_PERIOD = 100;

  typedef enum logic [2:0] {
    ST_MAIN_G = 3'd0,
    ST_MAIN_Y = 3'd1,
    ST_RED_A  = 3'd2,
    ST_SIDE_G = 3'd3,
    ST_SIDE_Y = 3'd4,
    ST_RED_B  = 3'd5,
    ST_FLASH  = 3'd6
  } phase_e;

  // Lamp encoding is one-hot {red, yellow, green}.
  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;
  localparam logic [2:0] LIGHT_OFF = 3'b000;

  // A zero duration would stall the down-counter at its terminal count, so it
  // is lifted to 1; anything beyond the two-digit display is capped at 99.
  function automatic logic [REMAIN_W-1:0] phase_dur(input int unsigned secs);
    if (secs == 0) begin
      return REMAIN_W'(1);
    end else if (secs > 99) begin
      return REMAIN_W'(99);
    end else begin
      return secs[REMAIN_W-1:0];
    end
  endfunction

  // Returns {main, side}. Only MAIN_G and SIDE_G carry a green, each paired
  // with red on the other road, so a green/green conflict has no encoding.
  function automatic logic [5:0] lights_of(input phase_e st, input logic blink);
    case (st)
      ST_MAIN_G: return {LIGHT_GRN, LIGHT_RED};
      ST_MAIN_Y: return {LIGHT_YEL, LIGHT_RED};
      ST_SIDE_G: return {LIGHT_RED, LIGHT_GRN};
      ST_SIDE_Y: return {LIGHT_RED, LIGHT_YEL};
      ST_FLASH:  return blink ? {LIGHT_YEL, LIGHT_YEL} : {LIGHT_OFF, LIGHT_OFF};
      default:   return {LIGHT_RED, LIGHT_RED};
    endcase
  endfunction

endpackage

// File: rtl/second_counter.sv
// One-second tick generator: a down-counter that reloads at its terminal count.
// Ports:
//   clk, rst_n     - clock, async active-low reset
//   en             - count enable; when low the count holds and no tick is issued
//   second_finish  - one-cycle tick, high while the count is at zero and enabled
//   pre_last       - high one enabled cycle before second_finish
module second_counter #(
  parameter int unsigned PERIOD = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic second_finish,
  output logic pre_last
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == '0) ? CNT_LOAD : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign second_finish = en && (cnt_q == '0);
  assign pre_last      = en && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase sequencer driven by a one-second tick.
// Ports:
//   clk, rst_n    - clock, async active-low reset
//   run           - 1 advances the cycle, 0 freezes tick generator and state
//   side_req      - side-road sensor / pedestrian button (level or pulse)
//   flash         - forces flashing-yellow fallback
//   main_light    - main road lamps, one-hot {red, yellow, green}
//   side_light    - side road lamps, one-hot {red, yellow, green}
//   remain        - seconds left in the current phase
//   side_pending  - a side request is latched and not yet served
//   phase         - current state code
//
// state  | meaning
// -------+----------------------------------------------------
// MAIN_G | main green; held at remain=1 until a side request
// MAIN_Y | main yellow
// RED_A  | all-red clearance before side green
// SIDE_G | side green; side request latch cleared on entry
// SIDE_Y | side yellow
// RED_B  | all-red clearance before main green; reset state
// FLASH  | both yellow blinking on each tick, remain forced to 0
module traffic_phase_ctrl
  import traffic_phase_ctrl_pkg::*;
#(
  parameter int unsigned T_MAIN_G = 10,
  parameter int unsigned T_MAIN_Y = 3,
  parameter int unsigned T_SIDE_G = 6,
  parameter int unsigned T_SIDE_Y = 3,
  parameter int unsigned T_ALLRED = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                side_req,
  input  logic                flash,
  output logic [2:0]          main_light,
  output logic [2:0]          side_light,
  output logic [REMAIN_W-1:0] remain,
  output logic                side_pending,
  output logic [2:0]          phase
);

  localparam logic [REMAIN_W-1:0] DUR_MAIN_G = phase_dur(T_MAIN_G);
  localparam logic [REMAIN_W-1:0] DUR_MAIN_Y = phase_dur(T_MAIN_Y);
  localparam logic [REMAIN_W-1:0] DUR_SIDE_G = phase_dur(T_SIDE_G);
  localparam logic [REMAIN_W-1:0] DUR_SIDE_Y = phase_dur(T_SIDE_Y);
  localparam logic [REMAIN_W-1:0] DUR_ALLRED = phase_dur(T_ALLRED);

  logic tick;
  logic unused_pre_last;

  second_counter #(
    .PERIOD(SEC_PERIOD)
  ) u_sec (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (run),
    .second_finish(tick),
    .pre_last     (unused_pre_last)
  );

  phase_e              state_q, state_d;
  logic [REMAIN_W-1:0] remain_q, remain_d;
  logic                blink_q, blink_d;
  logic                side_pending_q, side_pending_d;
  logic [2:0]          main_light_q, main_light_d;
  logic [2:0]          side_light_q, side_light_d;

  always_comb begin
    state_d        = state_q;
    remain_d       = remain_q;
    blink_d        = blink_q;
    side_pending_d = side_pending_q;

    if (flash) begin
      state_d  = ST_FLASH;
      remain_d = '0;
      // Every FLASH episode starts dark; blink only toggles once inside.
      if (state_q != ST_FLASH) begin
        blink_d = 1'b0;
      end else if (tick) begin
        blink_d = ~blink_q;
      end
    end else if (state_q == ST_FLASH) begin
      // Leaving flash always passes through all-red before main green.
      state_d  = ST_RED_B;
      remain_d = DUR_ALLRED;
      blink_d  = 1'b0;
    end else if (tick) begin
      if (remain_q > REMAIN_W'(1)) begin
        remain_d = remain_q - REMAIN_W'(1);
      end else if ((state_q == ST_MAIN_G) && !side_pending_q) begin
        remain_d = REMAIN_W'(1);
      end else begin
        case (state_q)
          ST_MAIN_G: begin state_d = ST_MAIN_Y; remain_d = DUR_MAIN_Y; end
          ST_MAIN_Y: begin state_d = ST_RED_A;  remain_d = DUR_ALLRED; end
          ST_RED_A:  begin state_d = ST_SIDE_G; remain_d = DUR_SIDE_G; end
          ST_SIDE_G: begin state_d = ST_SIDE_Y; remain_d = DUR_SIDE_Y; end
          ST_SIDE_Y: begin state_d = ST_RED_B;  remain_d = DUR_ALLRED; end
          default:   begin state_d = ST_MAIN_G; remain_d = DUR_MAIN_G; end
        endcase
      end
    end

    if (run) begin
      side_pending_d = side_pending_q | side_req;
    end
    // Entering side green serves the request; this beats a same-cycle request.
    if ((state_d == ST_SIDE_G) && (state_q != ST_SIDE_G)) begin
      side_pending_d = 1'b0;
    end

    {main_light_d, side_light_d} = lights_of(state_d, blink_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RED_B;
      remain_q       <= DUR_ALLRED;
      blink_q        <= 1'b0;
      side_pending_q <= 1'b0;
      main_light_q   <= LIGHT_RED;
      side_light_q   <= LIGHT_RED;
    end else begin
      state_q        <= state_d;
      remain_q       <= remain_d;
      blink_q        <= blink_d;
      side_pending_q <= side_pending_d;
      main_light_q   <= main_light_d;
      side_light_q   <= side_light_d;
    end
  end

  assign main_light   = main_light_q;
  assign side_light   = side_light_q;
  assign remain       = remain_q;
  assign side_pending = side_pending_q;
  assign phase        = state_q;

endmodule
